// File: rtl/swmf_pkg.sv
// -----------------------------------------------------------------------------
// swmf_pkg
// Shared definitions for the sliding-window front end: default image and pixel
// sizes, the row-major index of each position in the 3x3 window, and the
// window generator's sequencing states.
// -----------------------------------------------------------------------------
package swmf_pkg;

    localparam int PIX_W_DEFAULT = 8;
    localparam int IMG_W_DEFAULT = 256;
    localparam int IMG_H_DEFAULT = 256;

    // Window positions, row-major: top row 0..2, middle 3..5, bottom 6..8.
    localparam int WIN_SIZE = 9;
    localparam int WIN_TL   = 0;
    localparam int WIN_TC   = 1;
    localparam int WIN_TR   = 2;
    localparam int WIN_ML   = 3;
    localparam int WIN_MC   = 4;
    localparam int WIN_MR   = 5;
    localparam int WIN_BL   = 6;
    localparam int WIN_BC   = 7;
    localparam int WIN_BR   = 8;

    // IDLE : waiting for the first pixel of a frame
    // FILL : rows 0 and 1 are being loaded, no window possible yet
    // RUN  : row 2 onwards, windows produced from column 2 onwards
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// -----------------------------------------------------------------------------
// line_buffer
// One image line of pixel storage with a single address. The word at i_addr is
// presented on o_rd_data before the write of the same cycle lands, so the old
// content can be cascaded into a following buffer in the same cycle while the
// new pixel replaces it. Contents are not reset.
//
// Ports
//   Clk        : clock
//   i_addr     : column address, shared by read and write
//   i_we       : write enable (one accepted pixel)
//   i_wr_data  : word to store at i_addr
//   o_rd_data  : word currently stored at i_addr (old data on a write cycle)
// -----------------------------------------------------------------------------
module line_buffer
    import swmf_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEFAULT,
    parameter int WIDTH = PIX_W_DEFAULT
)(
    input  logic                     Clk,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic                     i_we,
    input  logic [WIDTH-1:0]         i_wr_data,
    output logic [WIDTH-1:0]         o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

    // The window output registers downstream act as the read register, which
    // keeps the one-cycle pixel-to-window latency while still cascading the
    // displaced word into the second buffer.
    assign o_rd_data = r_mem[i_addr];

endmodule

// File: rtl/window_generator.sv
// -----------------------------------------------------------------------------
// window_generator
// Builds a 3x3 pixel window from a raster-order pixel stream. Two line buffers
// keep the previous two rows, three 3-stage column shift registers hold the
// last three columns of rows r-2, r-1 and r. A window is published (registered)
// one cycle after each accepted pixel (r,c) with r>=2 and c>=2.
//
// Ports
//   Clk         : clock, all state changes on the rising edge
//   Rst         : asynchronous active-low reset
//   Pix_In      : pixel, sampled when Pix_Valid=1
//   Pix_Valid   : pixel strobe, always accepted (no backpressure)
//   Sof         : start of frame, qualified by Pix_Valid; pixel becomes (0,0)
//   X0..X8      : window, row-major, X0 top-left, X8 newest pixel
//   Win_Valid   : X0..X8 carry a fresh window this cycle
//   Frame_Done  : one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module window_generator
    import swmf_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEFAULT,
    parameter int IMG_H = IMG_H_DEFAULT,
    parameter int PIX_W = PIX_W_DEFAULT
)(
    input  logic             Clk,
    input  logic             Rst,
    input  logic [PIX_W-1:0] Pix_In,
    input  logic             Pix_Valid,
    input  logic             Sof,
    output logic [PIX_W-1:0] X0,
    output logic [PIX_W-1:0] X1,
    output logic [PIX_W-1:0] X2,
    output logic [PIX_W-1:0] X3,
    output logic [PIX_W-1:0] X4,
    output logic [PIX_W-1:0] X5,
    output logic [PIX_W-1:0] X6,
    output logic [PIX_W-1:0] X7,
    output logic [PIX_W-1:0] X8,
    output logic             Win_Valid,
    output logic             Frame_Done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(2);

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    w_col;
    logic [RW-1:0]    w_row;
    logic [CW-1:0]    w_col_next;
    logic [RW-1:0]    w_row_next;
    logic             w_restart;
    logic             w_last;
    logic             w_win_hit;

    logic [PIX_W-1:0] w_line1;              // row r-1 at column c
    logic [PIX_W-1:0] w_line2;              // row r-2 at column c
    logic [PIX_W-1:0] w_col_in [3];         // new column entering the shifters
    logic [PIX_W-1:0] r_sr     [WIN_SIZE];
    logic [PIX_W-1:0] w_sr_next[WIN_SIZE];
    logic [PIX_W-1:0] r_win    [WIN_SIZE];
    logic             r_win_valid;
    logic             r_frame_done;

    // ------------------------------------------------------------------
    // Coordinates of the pixel on the input this cycle. Out of IDLE, or on
    // any Sof, the pixel is (0,0); stale line-buffer rows are then harmless
    // because no window can be produced until two fresh rows have been seen.
    // ------------------------------------------------------------------
    assign w_restart = (r_state == IDLE) || Sof;
    assign w_col     = w_restart ? '0 : r_col;
    assign w_row     = w_restart ? '0 : r_row;
    assign w_last    = (w_row == ROW_LAST) && (w_col == COL_LAST);
    assign w_win_hit = (w_row >= ROW_FIRST_WIN) && (w_col >= COL_FIRST_WIN);

    always_comb begin
        w_col_next = w_col + CW'(1);
        w_row_next = w_row;
        if (w_col == COL_LAST) begin
            w_col_next = '0;
            w_row_next = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (Pix_Valid) begin
            if (w_last) begin
                w_state_next = IDLE;
            end else if (w_row >= ROW_FIRST_WIN) begin
                w_state_next = RUN;
            end else begin
                w_state_next = FILL;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: A holds row r-1, B holds row r-2. The word displaced
    // from A by the new pixel moves down into B at the same column.
    // ------------------------------------------------------------------
    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_line_a (
        .Clk       (Clk),
        .i_addr    (w_col),
        .i_we      (Pix_Valid),
        .i_wr_data (Pix_In),
        .o_rd_data (w_line1)
    );

    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_line_b (
        .Clk       (Clk),
        .i_addr    (w_col),
        .i_we      (Pix_Valid),
        .i_wr_data (w_line1),
        .o_rd_data (w_line2)
    );

    // ------------------------------------------------------------------
    // Column shift registers: each row shifts left, newest column at the
    // right-hand position (index 2, 5, 8).
    // ------------------------------------------------------------------
    assign w_col_in[0] = w_line2;
    assign w_col_in[1] = w_line1;
    assign w_col_in[2] = Pix_In;

    for (genvar gi = 0; gi < WIN_SIZE; gi++) begin : g_shift
        if ((gi % 3) == 2) begin : g_newest
            assign w_sr_next[gi] = w_col_in[gi / 3];
        end else begin : g_older
            assign w_sr_next[gi] = r_sr[gi + 1];
        end
    end

    // The window registers load only on a qualifying pixel so the published
    // window holds steady between valid windows.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < WIN_SIZE; i++) begin
                r_sr[i]  <= '0;
                r_win[i] <= '0;
            end
        end else if (Pix_Valid) begin
            for (int i = 0; i < WIN_SIZE; i++) begin
                r_sr[i] <= w_sr_next[i];
                if (w_win_hit) begin
                    r_win[i] <= w_sr_next[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters and strobes
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_win_valid  <= Pix_Valid && w_win_hit;
            r_frame_done <= Pix_Valid && w_last;
            if (Pix_Valid) begin
                r_col <= w_col_next;
                r_row <= w_row_next;
            end
        end
    end

    assign X0         = r_win[WIN_TL];
    assign X1         = r_win[WIN_TC];
    assign X2         = r_win[WIN_TR];
    assign X3         = r_win[WIN_ML];
    assign X4         = r_win[WIN_MC];
    assign X5         = r_win[WIN_MR];
    assign X6         = r_win[WIN_BL];
    assign X7         = r_win[WIN_BC];
    assign X8         = r_win[WIN_BR];
    assign Win_Valid  = r_win_valid;
    assign Frame_Done = r_frame_done;

endmodule

// File: tb/tb_window_generator.sv
// -----------------------------------------------------------------------------
// tb_window_generator
// Drives a 4x4 image stream into window_generator and compares every cycle
// against a reference that stores each frame as a 2-D image and cuts 3x3
// windows out of it by coordinates.
// -----------------------------------------------------------------------------
module tb_window_generator;

    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int PIX_W = 8;
    localparam logic [71:0] FIRST_WIN = 72'h00_01_02_04_05_06_08_09_0A;

    logic             Clk       = 1'b0;
    logic             Rst       = 1'b0;
    logic [PIX_W-1:0] Pix_In    = '0;
    logic             Pix_Valid = 1'b0;
    logic             Sof       = 1'b0;
    logic [PIX_W-1:0] X0, X1, X2, X3, X4, X5, X6, X7, X8;
    logic             Win_Valid;
    logic             Frame_Done;
    logic [71:0]      w_obs;

    always #5 Clk = ~Clk;

    window_generator #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (PIX_W)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Pix_In     (Pix_In),
        .Pix_Valid  (Pix_Valid),
        .Sof        (Sof),
        .X0         (X0),
        .X1         (X1),
        .X2         (X2),
        .X3         (X3),
        .X4         (X4),
        .X5         (X5),
        .X6         (X6),
        .X7         (X7),
        .X8         (X8),
        .Win_Valid  (Win_Valid),
        .Frame_Done (Frame_Done)
    );

    assign w_obs = {X0, X1, X2, X3, X4, X5, X6, X7, X8};

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    bit          m_in_frame = 1'b0;
    int          m_r = 0;
    int          m_c = 0;
    logic [7:0]  img [IMG_H][IMG_W];
    logic [71:0] exp_win = '0;

    int          dut_wins  = 0;
    int          dut_dones = 0;
    bit          arm_first = 1'b0;
    logic [71:0] first_win = '0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1 time unit after the
    // rising edge.
    task automatic step(input bit v, input bit s, input logic [7:0] p);
        bit ev;
        bit ed;
        ev = 1'b0;
        ed = 1'b0;
        @(negedge Clk);
        Pix_Valid = v;
        Sof       = s;
        Pix_In    = p;
        if (v) begin
            if (!m_in_frame || s) begin
                m_r        = 0;
                m_c        = 0;
                m_in_frame = 1'b1;
            end
            img[m_r][m_c] = p;
            ev = (m_r >= 2) && (m_c >= 2);
            ed = (m_r == IMG_H - 1) && (m_c == IMG_W - 1);
            if (ev) begin
                exp_win = '0;
                for (int i = 0; i < 3; i++) begin
                    for (int j = 0; j < 3; j++) begin
                        exp_win = {exp_win[63:0], img[m_r - 2 + i][m_c - 2 + j]};
                    end
                end
            end
            if (ed) begin
                m_in_frame = 1'b0;
            end else if (m_c == IMG_W - 1) begin
                m_c = 0;
                m_r++;
            end else begin
                m_c++;
            end
        end
        @(posedge Clk);
        #1;
        check("win_valid",  72'(Win_Valid),  72'(ev));
        check("frame_done", 72'(Frame_Done), 72'(ed));
        check("window",     w_obs,           exp_win);
        if (Win_Valid) begin
            dut_wins++;
            if (arm_first) begin
                first_win = w_obs;
                arm_first = 1'b0;
            end
            $display("win %0d pix=%h X=%h done=%0b", dut_wins, p, w_obs, Frame_Done);
        end
        if (Frame_Done) begin
            dut_dones++;
        end
    endtask

    // Pixel value 4r+c, Sof on the first pixel, optional idle cycles after each
    // pixel carrying random Sof/Pix_In that must be ignored.
    task automatic send_frame(input int gap, input int n_pix);
        for (int i = 0; i < n_pix; i++) begin
            step(1'b1, i == 0, 8'(i));
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            end
        end
    endtask

    task automatic check_counts(input string tag, input int w0, input int d0,
                                input int exp_w, input int exp_d);
        check({tag, "_wins"},  72'(dut_wins - w0),  72'(exp_w));
        check({tag, "_dones"}, 72'(dut_dones - d0), 72'(exp_d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int d0;
        int gap;
        bit s;

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst_valid",  72'(Win_Valid),  72'(0));
        check("rst_done",   72'(Frame_Done), 72'(0));
        check("rst_window", w_obs,           72'(0));
        Rst = 1'b1;

        // Continuous frame
        w0 = dut_wins; d0 = dut_dones; arm_first = 1'b1;
        send_frame(0, 16);
        check_counts("cont", w0, d0, 4, 1);
        check("cont_first", first_win, FIRST_WIN);

        // Three idle cycles after every pixel
        w0 = dut_wins; d0 = dut_dones; arm_first = 1'b1;
        send_frame(3, 16);
        check_counts("gap", w0, d0, 4, 1);
        check("gap_first", first_win, FIRST_WIN);

        // Frame aborted by Sof on its tenth pixel, then a fresh frame
        w0 = dut_wins; d0 = dut_dones; arm_first = 1'b1;
        send_frame(0, 9);
        send_frame(0, 16);
        check_counts("abort", w0, d0, 4, 1);
        check("abort_first", first_win, FIRST_WIN);

        // Asynchronous reset after pixel 11
        w0 = dut_wins; d0 = dut_dones;
        send_frame(0, 12);
        check_counts("pre_rst", w0, d0, 2, 0);
        #3;
        Rst        = 1'b0;
        m_in_frame = 1'b0;
        exp_win    = '0;
        #1;
        check("midrst_valid",  72'(Win_Valid),  72'(0));
        check("midrst_done",   72'(Frame_Done), 72'(0));
        check("midrst_window", w_obs,           72'(0));
        @(negedge Clk);
        Rst = 1'b1;
        w0 = dut_wins; d0 = dut_dones; arm_first = 1'b1;
        send_frame(0, 16);
        check_counts("post_rst", w0, d0, 4, 1);
        check("post_rst_first", first_win, FIRST_WIN);

        // Two back-to-back frames
        w0 = dut_wins; d0 = dut_dones;
        send_frame(0, 16);
        arm_first = 1'b1;
        send_frame(0, 16);
        check_counts("b2b", w0, d0, 8, 2);
        check("b2b_second_first", first_win, FIRST_WIN);

        // Random pixels, random gaps, occasional Sof aborts
        for (int k = 0; k < 300; k++) begin
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            s   = ($urandom_range(0, 49) == 0);
            step(1'b1, s, 8'($urandom));
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
            end
        end

        repeat (3) step(1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
